// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned SEL_W = 4;

    // Arbiter states; a 3-bit encoding leaves room for later states.
    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_ACC   = 3'd1,
        ARB_MEM_ACC  = 3'd2,
        ARB_IF_DONE  = 3'd3,
        ARB_MEM_DONE = 3'd4
    } arb_state_t;

    localparam logic             RST_ENABLE = 1'b0;
    localparam logic [SEL_W-1:0] SEL_ALL    = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage.
// MEM wins on conflict; an owned bus cycle is never preempted.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stallreq,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stallreq,

    output logic              bus_req,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    arb_state_t state;
    logic       flushed;

    // A flush seen during or coincident with the completing edge discards the fetch.
    logic       if_discard_c;
    assign if_discard_c = flushed | flush;

    // A requester holds until its DONE cycle, even while the other side owns the bus.
    assign if_stallreq  = if_req  && (state != ARB_IF_DONE);
    assign mem_stallreq = mem_req && (state != ARB_MEM_DONE);

    // Arbitration FSM with registered bus outputs and read-data capture.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= ARB_IDLE;
            flushed   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (mem_req) begin
                        state     <= ARB_MEM_ACC;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_sel   <= mem_sel;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (if_req) begin
                        state     <= ARB_IF_ACC;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_sel   <= SEL_ALL;
                        bus_addr  <= if_addr;
                        bus_wdata <= '0;
                    end
                end
                ARB_IF_ACC: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        flushed <= 1'b0;
                        if (if_discard_c) begin
                            state <= ARB_IDLE;
                        end else begin
                            if_rdata <= bus_rdata;
                            state    <= ARB_IF_DONE;
                        end
                    end else if (flush) begin
                        flushed <= 1'b1;
                    end
                end
                ARB_MEM_ACC: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        mem_rdata <= bus_rdata;
                        state     <= ARB_MEM_DONE;
                    end
                end
                ARB_IF_DONE:  state <= ARB_IDLE;
                ARB_MEM_DONE: state <= ARB_IDLE;
                default:      state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        if_req;
    logic [31:0] if_addr, if_rdata;
    logic        if_stallreq;
    logic        mem_req, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_stallreq;
    logic        bus_req, bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stallreq(if_stallreq),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_stallreq(mem_stallreq),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who has a transaction in flight, who is in its completion cycle.
    int          m_busy;     // 0 none, 1 fetch, 2 load/store
    int          m_done;     // 0 none, 1 fetch result, 2 load/store result
    bit          m_drop;     // in-flight fetch has been flushed
    logic        m_req, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_drop = 0;
        m_req = 0; m_we = 0; m_sel = 0; m_addr = 0; m_wdata = 0; m_if_rd = 0; m_mem_rd = 0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_busy == 0) begin
            if (mem_req) begin
                m_busy = 2; m_req = 1; m_we = mem_we; m_sel = mem_sel;
                m_addr = mem_addr; m_wdata = mem_wdata;
            end else if (if_req) begin
                m_busy = 1; m_req = 1; m_we = 0; m_sel = 4'hF; m_addr = if_addr; m_wdata = 0;
            end
        end else if (bus_ack) begin
            m_req = 0;
            if (m_busy == 2) begin
                m_mem_rd = bus_rdata; m_done = 2;
            end else if (!(m_drop || flush)) begin
                m_if_rd = bus_rdata; m_done = 1;
            end
            m_busy = 0; m_drop = 0;
        end else if (m_busy == 1 && flush) begin
            m_drop = 1;
        end
    endtask

    // One clock: combinational stalls checked mid-cycle, registered outputs after the edge.
    task automatic step();
        @(negedge clk);
        check("if_stallreq",  64'(if_stallreq),  64'(if_req  && m_done != 1));
        check("mem_stallreq", 64'(mem_stallreq), 64'(mem_req && m_done != 2));
        model_edge();
        @(posedge clk);
        #1;
        check("bus_req",   64'(bus_req),   64'(m_req));
        check("bus_we",    64'(bus_we),    64'(m_we));
        check("bus_sel",   64'(bus_sel),   64'(m_sel));
        check("bus_addr",  64'(bus_addr),  64'(m_addr));
        check("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
        check("if_rdata",  64'(if_rdata),  64'(m_if_rd));
        check("mem_rdata", 64'(mem_rdata), 64'(m_mem_rd));
    endtask

    task automatic idle_inputs();
        flush = 0; if_req = 0; mem_req = 0; bus_ack = 0;
    endtask

    initial begin
        int done_cnt;
        model_reset();
        rst = 0; flush = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_sel = 0; mem_addr = 0; mem_wdata = 0; bus_rdata = 0; bus_ack = 1;
        step();  // reset with a stray ack present
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_if_rdata", 64'(if_rdata), 64'd0);
        rst = 1; bus_ack = 0;

        // IF only, ack in the second bus cycle
        if_req = 1; if_addr = 32'h100;
        step();
        check("t1_bus_req", 64'(bus_req), 64'd1);
        check("t1_bus_addr", 64'(bus_addr), 64'h100);
        check("t1_bus_sel", 64'(bus_sel), 64'hF);
        check("t1_bus_we", 64'(bus_we), 64'd0);
        check("t1_stall_acc", 64'(if_stallreq), 64'd1);
        step();
        bus_ack = 1; bus_rdata = 32'hCAFE0001;
        step();
        bus_ack = 0;
        check("t1_stall_done", 64'(if_stallreq), 64'd0);
        check("t1_if_rdata", 64'(if_rdata), 64'hCAFE0001);
        check("t1_bus_req_off", 64'(bus_req), 64'd0);
        if_req = 0;
        step();

        // Simultaneous requests: MEM store wins
        if_req = 1; if_addr = 32'h300;
        mem_req = 1; mem_we = 1; mem_sel = 4'b0011; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        step();
        check("t2_bus_we", 64'(bus_we), 64'd1);
        check("t2_bus_addr", 64'(bus_addr), 64'h2000);
        check("t2_bus_sel", 64'(bus_sel), 64'h3);
        check("t2_bus_wdata", 64'(bus_wdata), 64'hDEADBEEF);
        bus_ack = 1; bus_rdata = 32'h0;
        step();
        bus_ack = 0;
        check("t2_mem_stall_done", 64'(mem_stallreq), 64'd0);
        check("t2_if_stall_wait", 64'(if_stallreq), 64'd1);
        mem_req = 0;
        step();
        check("t2_idle_gap", 64'(bus_req), 64'd0);
        step();
        check("t2_if_start", 64'(bus_req), 64'd1);
        check("t2_if_addr", 64'(bus_addr), 64'h300);
        bus_ack = 1; bus_rdata = 32'hCAFE0002;
        step();
        idle_inputs();
        step();

        // Flush during IF access discards the result
        if_req = 1; if_addr = 32'h200;
        step();
        flush = 1;
        step();
        flush = 0; if_req = 0; bus_ack = 1; bus_rdata = 32'h12345678;
        step();
        check("t4_if_rdata_kept", 64'(if_rdata), 64'hCAFE0002);
        check("t4_bus_req_off", 64'(bus_req), 64'd0);
        bus_ack = 0;
        step();

        // Reset mid MEM access, then stray ack afterwards
        mem_req = 1; mem_we = 0; mem_addr = 32'h4000; mem_sel = 4'hF;
        step();
        check("t5_bus_req_on", 64'(bus_req), 64'd1);
        rst = 0;
        step();
        check("t5_bus_req_rst", 64'(bus_req), 64'd0);
        rst = 1; mem_req = 0; bus_ack = 1; bus_rdata = 32'h5555AAAA;
        step();
        check("t5_stray_ack", 64'(bus_req), 64'd0);
        check("t5_mem_rdata", 64'(mem_rdata), 64'd0);
        bus_ack = 0;
        step();

        // Zero-wait slave, back-to-back loads: one access per three cycles
        mem_req = 1; mem_we = 0; bus_ack = 1; done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            bus_rdata = $urandom;
            mem_addr = 32'h8000 + 32'(i);
            step();
            if (!mem_stallreq) done_cnt++;
        end
        check("t6_done_count", 64'(done_cnt), 64'd3);
        idle_inputs();
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 63) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            if_req    = ($urandom_range(0, 1) == 1);
            if_addr   = $urandom;
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_we    = $urandom_range(0, 1) == 1;
            mem_sel   = 4'($urandom);
            mem_addr  = $urandom;
            mem_wdata = $urandom;
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
